// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit for the EX stage.
// Runs one shift-add (MUL) or restoring shift-subtract (DIV) step per clock
// on operand magnitudes. Result signs are applied when the final step is
// registered into hi/lo.
//
// Handshake: start is a request that is accepted only when the unit is idle
// and flush is low. Acceptance makes busy rise on the next cycle. done is a
// one-cycle pulse that marks new hi/lo/div_by_zero contents. The next start
// can be accepted in the cycle after done. A request raised while busy or
// done is high is dropped, not queued. flush abandons an operation in flight
// without a done pulse.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // MUL: upper partial product, DIV: partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;       // MUL: multiplier / low product, DIV: dividend / quotient
  logic [WIDTH-1:0] b_q, b_d;         // magnitude of multiplier-side or divisor operand
  logic [WIDTH-1:0] a_raw_q, a_raw_d; // raw dividend, returned on divide by zero
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_out_q, dbz_out_d;

  logic             a_neg, b_neg, accept, last_step;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_sh, div_trial;
  logic [WIDTH-1:0] it_acc, it_sh;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign busy        = (state_q == MUL) || (state_q == DIV);
  assign done        = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_out_q;
  assign dbg_state   = state_q;

  assign accept    = (state_q == IDLE) && start && !flush;
  assign last_step = busy && !flush && (cnt_q == LAST);

  // Launch-time sign bookkeeping: signed ops work on magnitudes
  always_comb begin
    a_neg = op[0] & A[WIDTH-1];
    b_neg = op[0] & B[WIDTH-1];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;
  end

  // One iteration step plus the sign-corrected forms of its result
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
    div_sh    = {acc_q, sh_q[WIDTH-1]};
    div_trial = div_sh - {1'b0, b_q};
    if (state_q == DIV) begin
      // A borrow out of the trial subtraction means the divisor did not fit.
      if (!div_trial[WIDTH]) begin
        it_acc = div_trial[WIDTH-1:0];
        it_sh  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        it_acc = div_sh[WIDTH-1:0];
        it_sh  = {sh_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      it_acc = mul_sum[WIDTH:1];
      it_sh  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end
    prod_fix = neg_lo_q ? -{it_acc, it_sh} : {it_acc, it_sh};
    quo_fix  = neg_lo_q ? -it_sh : it_sh;
    rem_fix  = neg_hi_q ? -it_acc : it_acc;
  end

  // Next-state logic for the control FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !flush) state_d = op[1] ? DIV : MUL;
      MUL, DIV: begin
        if (flush)               state_d = IDLE;
        else if (cnt_q == LAST)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate while busy, register result
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    b_d       = b_q;
    a_raw_d   = a_raw_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_out_d = dbz_out_q;
    if (accept) begin
      cnt_d     = '0;
      acc_d     = '0;
      sh_d      = a_mag;
      b_d       = b_mag;
      a_raw_d   = A;
      neg_lo_d  = a_neg ^ b_neg;
      neg_hi_d  = a_neg;
      dbz_d     = op[1] && (B == '0);
      dbz_out_d = 1'b0;
    end else if (busy && !flush) begin
      cnt_d = last_step ? '0 : cnt_q + CW'(1);
      acc_d = it_acc;
      sh_d  = it_sh;
      if (last_step) begin
        if (state_q == MUL) begin
          {hi_d, lo_d} = prod_fix;
        end else if (dbz_q) begin
          hi_d      = a_raw_q;
          lo_d      = '1;
          dbz_out_d = 1'b1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      b_q       <= '0;
      a_raw_q   <= '0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      b_q       <= b_d;
      a_raw_q   <= a_raw_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_out_q <= dbz_out_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed checks of mul_div_unit against an arithmetic model.
module tb_mul_div_unit;
  localparam int W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
    logic         e_dbz;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;

  logic [2*W:0] exp_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_dbz = 1'b0;
  bit           run_cmp = 1'b0;

  vec_t vecs[11];

  mul_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .A           (A),
    .B           (B),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // Clock
  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
    end
  endtask

  // Arithmetic reference: {div_by_zero, hi, lo}
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint       sa, sb, sq, sr;
    logic [2*W-1:0] p;
    logic [2*W:0]   r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (o)
      2'd0: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r = {1'b0, p};
      end
      2'd1: begin
        p = sa * sb;
        r = {1'b0, p};
      end
      default: begin
        if (b == '0) begin
          r = {1'b1, a, {W{1'b1}}};
        end else if (o == 2'd2) begin
          r = {1'b0, a % b, a / b};
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {1'b0, sr[W-1:0], sq[W-1:0]};
        end
      end
    endcase
    return r;
  endfunction

  // Scoreboard: visible hi/lo/div_by_zero must equal the last completed result
  always @(negedge clk) begin : cmp_proc
    logic [2*W:0] e;
    if (rst_n && run_cmp) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          e     = exp_q.pop_front();
          m_dbz = e[2*W];
          m_hi  = e[2*W-1:W];
          m_lo  = e[W-1:0];
        end
      end
      chk("cmp_hi", hi, m_hi);
      chk("cmp_lo", lo, m_lo);
      chk("cmp_dbz", {{(W-1){1'b0}}, div_by_zero}, {{(W-1){1'b0}}, m_dbz});
    end
  end

  // Driver: full operation with hand-computed result; optional stray start while busy
  task automatic run_op(input vec_t v, input int noise_at);
    int cyc;
    int busy_cyc;
    @(negedge clk);
    start = 1'b1; op = v.op; A = v.a; B = v.b;
    exp_q.push_back(model(v.op, v.a, v.b));
    @(posedge clk);
    #1 m_dbz = 1'b0;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    A = $urandom;
    B = $urandom;
    cyc = 0;
    busy_cyc = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cyc++;
      if (cyc == noise_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk("done_seen", {{(W-1){1'b0}}, done}, 1);
    chk("latency", cyc, W);
    chk("busy_cycles", busy_cyc, W);
    chk("busy_at_done", {{(W-1){1'b0}}, busy}, 0);
    chk("res_hi", hi, v.e_hi);
    chk("res_lo", lo, v.e_lo);
    chk("res_dbz", {{(W-1){1'b0}}, div_by_zero}, {{(W-1){1'b0}}, v.e_dbz});
    @(negedge clk);
    chk("done_pulse", {{(W-1){1'b0}}, done}, 0);
    chk("idle_busy", {{(W-1){1'b0}}, busy}, 0);
  endtask

  // Driver: launch then flush after flush_at busy cycles; no result expected
  task automatic flush_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int flush_at);
    int dones;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1 m_dbz = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (flush_at) @(negedge clk);
    chk("busy_pre_flush", {{(W-1){1'b0}}, busy}, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("busy_post_flush", {{(W-1){1'b0}}, busy}, 0);
    chk("done_post_flush", {{(W-1){1'b0}}, done}, 0);
    dones = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("flush_no_done", dones, 0);
  endtask

  // Driver: start and flush together in idle; nothing may launch
  task automatic start_with_flush();
    int dones;
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'd0; A = 32'd5; B = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("sf_busy", {{(W-1){1'b0}}, busy}, 0);
    dones = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("sf_no_done", dones, 0);
  endtask

  // Driver: asynchronous reset in the middle of a DIV
  task automatic reset_mid_div();
    @(negedge clk);
    start = 1'b1; op = 2'd3; A = 32'hFFFF_0000; B = 32'd7;
    @(posedge clk);
    #1 m_dbz = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("busy_pre_reset", {{(W-1){1'b0}}, busy}, 1);
    #2 rst_n = 1'b0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", {{(W-1){1'b0}}, busy}, 0);
    chk("rst_done", {{(W-1){1'b0}}, done}, 0);
    chk("rst_dbz", {{(W-1){1'b0}}, div_by_zero}, 0);
    repeat (2) @(negedge clk);
    chk("rst_hold_done", {{(W-1){1'b0}}, done}, 0);
    rst_n = 1'b1;
  endtask

  // Stimulus sequence and final report
  initial begin
    vecs[0]  = '{2'd0, 32'd7,          32'd6,          32'h0000_0000, 32'h0000_002A, 1'b0};
    vecs[1]  = '{2'd1, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2]  = '{2'd3, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'd2, 32'd100,        32'd7,          32'd2,         32'd14,        1'b0};
    vecs[4]  = '{2'd2, 32'h0000_0064,  32'd0,          32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{2'd3, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6]  = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[7]  = '{2'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[8]  = '{2'd3, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{2'd1, 32'h1234_5678,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hEDCB_A988, 1'b0};
    vecs[10] = '{2'd3, 32'd0,          32'd0,          32'h0000_0000, 32'hFFFF_FFFF, 1'b1};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", {{(W-1){1'b0}}, busy}, 0);
    chk("reset_done", {{(W-1){1'b0}}, done}, 0);
    chk("reset_dbz", {{(W-1){1'b0}}, div_by_zero}, 0);
    #2 rst_n = 1'b1;
    run_cmp = 1'b1;

    foreach (vecs[i]) run_op(vecs[i], -1);

    // Stray start pulse mid-operation must not disturb 3*3
    run_op('{2'd0, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0}, 12);
    // Flush at iteration 10 keeps hi=0, lo=9 from the previous result
    flush_op(2'd0, 32'd3, 32'd3, 10);
    start_with_flush();
    reset_mid_div();
    run_op('{2'd2, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0}, -1);

    repeat (2) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
